// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: emits A/B/Z, single-turn position and a cumulative step count.
// Latency: outputs update on the same clock edge as the prescaler's step event; first step 'period' clocks after enable.
// Backpressure: none; free-running source, enable=0 or period=0 freezes all outputs.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   enable, dir       run/hold and direction (1 = forward / position increments)
//   period            clocks per quadrature edge (0 = no stepping)
//   pulses_per_rev    maximum position value; position spans 0..pulses_per_rev
//   A, B, Z           registered quadrature and index outputs
//   position, counter single-revolution position and wrapping two's-complement step count
//   step              one-clock pulse coincident with each A/B change
//
// Optional feature ENC_EMU_STEP_LIMIT_EN: adds steps_target input and done output; the
// emitter stops after steps_target steps per enable assertion and raises done.
module encoder_emulator #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] period,
    input  logic [31:0]         pulses_per_rev,
`ifdef ENC_EMU_STEP_LIMIT_EN
    input  logic [31:0]         steps_target,
    output logic                done,
`endif
    output logic                A,
    output logic                B,
    output logic                Z,
    output logic [31:0]         position,
    output logic [31:0]         counter,
    output logic                step
);

    logic [PERIOD_W-1:0] pcnt;
    logic                run;
    logic                limit_hit;
    logic                step_evt;

    logic                a_nxt;
    logic                b_nxt;
    logic [31:0]         pos_nxt;
    logic [31:0]         cnt_nxt;

    assign run = enable && (period != '0);

`ifdef ENC_EMU_STEP_LIMIT_EN
    logic [31:0] steps_done;
    assign limit_hit = (steps_done == steps_target);
`else
    assign limit_hit = 1'b0;
`endif

    // '>=' rather than '==' so that shrinking period below the current count
    // fires on the next clock instead of wrapping through the full counter range.
    assign step_evt = run && !limit_hit && (pcnt >= period - PERIOD_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!run || limit_hit || step_evt) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PERIOD_W'(1);
        end
    end

    // Forward walks 00->10->11->01, reverse is the exact inverse; both are a
    // single-bit rotation of {A,B} with one inversion, so only one line toggles.
    always_comb begin
        a_nxt   = A;
        b_nxt   = B;
        pos_nxt = position;
        cnt_nxt = counter;
        if (dir) begin
            a_nxt   = ~B;
            b_nxt   = A;
            cnt_nxt = counter + 32'd1;
            // '>=' also catches a position stranded above a freshly lowered limit.
            pos_nxt = (position >= pulses_per_rev) ? 32'd0 : position + 32'd1;
        end else begin
            a_nxt   = B;
            b_nxt   = ~A;
            cnt_nxt = counter - 32'd1;
            pos_nxt = (position == 32'd0) ? pulses_per_rev : position - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A        <= 1'b0;
            B        <= 1'b0;
            Z        <= 1'b0;
            position <= '0;
            counter  <= '0;
            step     <= 1'b0;
        end else begin
            step <= step_evt;
            if (step_evt) begin
                A        <= a_nxt;
                B        <= b_nxt;
                Z        <= (pos_nxt == 32'd0);
                position <= pos_nxt;
                counter  <= cnt_nxt;
            end
        end
    end

`ifdef ENC_EMU_STEP_LIMIT_EN
    logic [31:0] steps_done_nxt;
    assign steps_done_nxt = step_evt ? steps_done + 32'd1 : steps_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_done <= '0;
            done       <= 1'b0;
        end else if (!enable) begin
            steps_done <= '0;
            done       <= 1'b0;
        end else begin
            steps_done <= steps_done_nxt;
            // Look at the post-step count so done rises on the edge of the final step.
            done       <= (steps_done_nxt == steps_target);
        end
    end
`endif

endmodule

// File: tb/tb_encoder_emulator.sv
`timescale 1ns/1ps
module tb_encoder_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        dir;
    logic [31:0] period;
    logic [31:0] ppr;
    logic        A, B, Z, step;
    logic [31:0] position, counter;
`ifdef ENC_EMU_STEP_LIMIT_EN
    logic [31:0] steps_target = 32'hFFFF_FFFF;
    logic        done;
`endif

    always #5 clk = ~clk;

    encoder_emulator #(.PERIOD_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .dir(dir),
        .period(period),
        .pulses_per_rev(ppr),
`ifdef ENC_EMU_STEP_LIMIT_EN
        .steps_target(steps_target),
        .done(done),
`endif
        .A(A),
        .B(B),
        .Z(Z),
        .position(position),
        .counter(counter),
        .step(step)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural reference model ----------------
    // Quadrature modelled as a phase index into the forward Gray table.
    logic [1:0]  ab_of [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    longint      m_el;
    int          m_ph;
    logic [31:0] m_pos, m_cnt;
    bit          m_z, m_stp;

    function automatic void model_reset();
        m_el = 0; m_ph = 0; m_pos = 0; m_cnt = 0; m_z = 0; m_stp = 0;
    endfunction

    function automatic void model_edge();
        longint p64;
        m_stp = 0;
        if (enable && period != 0) begin
            m_el++;
            if (m_el >= longint'(period)) begin
                m_el  = 0;
                m_stp = 1;
                p64   = longint'(ppr);
                if (dir) begin
                    m_ph  = (m_ph + 1) % 4;
                    m_cnt = m_cnt + 1;
                    if (longint'(m_pos) > p64) m_pos = 0;
                    else m_pos = 32'((longint'(m_pos) + 1) % (p64 + 1));
                end else begin
                    m_ph  = (m_ph + 3) % 4;
                    m_cnt = m_cnt - 1;
                    m_pos = (m_pos == 0) ? ppr : m_pos - 1;
                end
                m_z = (m_pos == 0);
            end
        end else begin
            m_el = 0;
        end
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [67:0] pk(logic [1:0] ab, bit z, bit s, logic [31:0] pos, logic [31:0] cnt);
        return {ab, z, s, pos, cnt};
    endfunction

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got AB=%b Z=%b step=%b pos=%0d cnt=%h want AB=%b Z=%b step=%b pos=%0d cnt=%h",
                     name, act[67:66], act[65], act[64], act[63:32], act[31:0],
                     exp[67:66], exp[65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    function automatic logic [67:0] dut_vec();
        return {A, B, Z, step, position, counter};
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        bit          en;
        bit          dr;
        logic [31:0] per;
        logic [31:0] lim;
        int          cyc;
        logic [1:0]  ab;
        bit          z;
        logic [31:0] pos;
        logic [31:0] cnt;
        bit          stp;
    } vec_t;

    vec_t vt[17];

    initial begin
        rst_n = 1'b0; enable = 1'b0; dir = 1'b1; period = 32'd4; ppr = 32'd7;

        //          rst en dr per lim cyc  ab    z  pos cnt           stp
        vt[0]  = '{1, 0, 1, 4, 7, 0, 2'b00, 0, 0, 0,            0};
        vt[1]  = '{0, 1, 1, 4, 7, 3, 2'b00, 0, 0, 0,            0};
        vt[2]  = '{0, 1, 1, 4, 7, 1, 2'b10, 0, 1, 1,            1};
        vt[3]  = '{0, 1, 1, 4, 7, 1, 2'b10, 0, 1, 1,            0};
        vt[4]  = '{0, 1, 1, 4, 7, 3, 2'b11, 0, 2, 2,            1};
        vt[5]  = '{0, 1, 1, 4, 7, 4, 2'b01, 0, 3, 3,            1};
        vt[6]  = '{0, 1, 1, 4, 7, 4, 2'b00, 0, 4, 4,            1};
        vt[7]  = '{1, 1, 1, 1, 3, 1, 2'b10, 0, 1, 1,            1};
        vt[8]  = '{0, 1, 1, 1, 3, 2, 2'b01, 0, 3, 3,            1};
        vt[9]  = '{0, 1, 1, 1, 3, 1, 2'b00, 1, 0, 4,            1};
        vt[10] = '{0, 1, 1, 1, 3, 4, 2'b00, 1, 0, 8,            1};
        vt[11] = '{1, 1, 0, 2, 5, 2, 2'b01, 0, 5, 32'hFFFFFFFF, 1};
        vt[12] = '{0, 1, 0, 2, 5, 1, 2'b01, 0, 5, 32'hFFFFFFFF, 0};
        vt[13] = '{0, 0, 0, 2, 5, 5, 2'b01, 0, 5, 32'hFFFFFFFF, 0};
        vt[14] = '{1, 1, 1, 3, 7, 9, 2'b01, 0, 3, 3,            1};
        vt[15] = '{0, 1, 0, 3, 7, 3, 2'b11, 0, 2, 2,            1};
        vt[16] = '{0, 1, 0, 3, 7, 3, 2'b10, 0, 1, 1,            1};

        for (int i = 0; i < 17; i++) begin
            enable = vt[i].en; dir = vt[i].dr; period = vt[i].per; ppr = vt[i].lim;
            if (vt[i].rst) do_reset();
            repeat (vt[i].cyc) cycle();
            chk($sformatf("vec%0d", i), dut_vec(),
                pk(vt[i].ab, vt[i].z, vt[i].stp, vt[i].pos, vt[i].cnt));
        end

        // Period shrinks below the running count, then enable bounces mid-period.
        enable = 1; dir = 1; period = 100; ppr = 7;
        do_reset();
        repeat (50) cycle();
        chk("long_period_idle", dut_vec(), pk(2'b00, 0, 0, 0, 0));
        period = 5;
        cycle();
        chk("shrink_fires_next", dut_vec(), pk(2'b10, 0, 1, 1, 1));
        repeat (4) cycle();
        chk("shrink_gap", dut_vec(), pk(2'b10, 0, 0, 1, 1));
        cycle();
        chk("shrink_steady", dut_vec(), pk(2'b11, 0, 1, 2, 2));
        repeat (2) cycle();
        enable = 0;
        repeat (3) cycle();
        chk("enable_low_hold", dut_vec(), pk(2'b11, 0, 0, 2, 2));
        enable = 1;
        repeat (4) cycle();
        chk("reenable_no_early", dut_vec(), pk(2'b11, 0, 0, 2, 2));
        cycle();
        chk("reenable_full_period", dut_vec(), pk(2'b01, 0, 1, 3, 3));

        // Limit lowered below the current position.
        enable = 1; dir = 1; period = 1; ppr = 7;
        do_reset();
        repeat (5) cycle();
        ppr = 3;
        cycle();
        chk("limit_drop_fwd", dut_vec(), pk(2'b11, 1, 1, 0, 6));
        ppr = 7;
        do_reset();
        repeat (5) cycle();
        ppr = 3; dir = 0;
        cycle();
        chk("limit_drop_rev", dut_vec(), pk(2'b00, 0, 1, 4, 4));

        // Counter wraps both ways.
        dir = 0; ppr = 7;
        do_reset();
        cycle();
        chk("cnt_wrap_down", dut_vec(), pk(2'b01, 0, 1, 7, 32'hFFFFFFFF));
        dir = 1;
        cycle();
        chk("cnt_wrap_up", dut_vec(), pk(2'b00, 1, 1, 0, 0));

        // Randomized run against the model, including asynchronous resets.
        enable = 1; dir = 1; period = 2; ppr = 5;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0)  dir = ~dir;
            if ($urandom_range(0, 39) == 0) period = $urandom_range(0, 5);
            if ($urandom_range(0, 49) == 0) ppr = $urandom_range(0, 6);
            if ($urandom_range(0, 29) == 0) enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("rand_async_reset", dut_vec(), pk(2'b00, 0, 0, 0, 0));
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            cycle();
            chk($sformatf("rand_cyc%0d", n), dut_vec(),
                pk(ab_of[m_ph], m_z, m_stp, m_pos, m_cnt));
        end

`ifdef ENC_EMU_STEP_LIMIT_EN
        begin
            int np;
            np = 0;
            enable = 0; dir = 1; period = 2; ppr = 31;
            do_reset();
            steps_target = 10;
            enable = 1;
            for (int i = 1; i <= 24; i++) begin
                cycle();
                if (step) np++;
                if (i == 19) chk("done_before", {67'd0, done}, 68'd0);
                if (i == 20) chk("done_at_20", {67'd0, done}, 68'd1);
            end
            chk("limit_pulses", 68'(np), 68'd10);
            chk("limit_counter", 68'(counter), 68'd10);
            enable = 0;
            repeat (2) cycle();
            chk("done_clears", {67'd0, done}, 68'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
